cus43_fetch_sequencer: RTL and testbench

Sequences all tile-map VRAM accesses for the CUS43 dual tilemap generator on the 6 MHz pixel clock. Inside every 8-pixel tile window it fetches the code and attribute bytes for layer A and layer B, then gives the remaining slots to the CPU. It also holds the per-layer scroll and priority registers written through LATCH/CA/MDI. Its registered strobes drive the CUS43 tile/attribute latches, and its scroll/priority outputs feed the pixel shifter and the priority mux.

---
 rtl/cus43_fetch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cus43_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cus43_fetch_sequencer.sv
// CUS43 tile-map VRAM sequencer: per-tile fetch of code/attribute for layers A and B,
// CPU access slots, and the per-layer scroll/priority register file.
module cus43_fetch_sequencer (
  input  logic        CLK_6M,
  input  logic        RST_N,
  input  logic [8:0]  HCNT,
  input  logic [7:0]  VCNT,
  input  logic        FLIP,
  input  logic        LATCH,
  input  logic [2:0]  CA,
  input  logic [7:0]  MDI,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [12:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  input  logic [7:0]  VRAM_DI,
  output logic [12:0] VRAM_A,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_DO,
  output logic [1:0]  CODE_LATCH,
  output logic [1:0]  ATTR_LATCH,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_RDATA,
  output logic [2:0]  PRI_A,
  output logic [2:0]  PRI_B,
  output logic [2:0]  FINE_A,
  output logic [2:0]  FINE_B
);

  logic [1:0][8:0] hscroll_q, hscroll_d;
  logic [1:0][7:0] vscroll_q, vscroll_d;
  logic [1:0][2:0] pri_q, pri_d;
  logic [1:0][2:0] pri_out_q, pri_out_d;
  logic [1:0][2:0] fine_out_q, fine_out_d;
  logic [12:0]     vram_a_q, vram_a_d;
  logic            vram_we_q, vram_we_d;
  logic [7:0]      vram_do_q, vram_do_d;
  logic [1:0]      code_latch_q, code_latch_d;
  logic [1:0]      attr_latch_q, attr_latch_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic            grant_q, grant_d;
  logic [2:0]      slot_s;

  // Column is offset by one tile so the fetched tile is ready when the shifter needs it.
  function automatic logic [12:0] fetch_addr(
    input logic       layer,
    input logic       is_attr,
    input logic [8:0] hs,
    input logic [7:0] vs,
    input logic [8:0] hcnt,
    input logic [7:0] vcnt,
    input logic       flip
  );
    logic [8:0] h;
    logic [8:0] col_sum;
    logic [7:0] v;
    logic [7:0] row_sum;
    h       = flip ? ~hcnt : hcnt;
    v       = flip ? ~vcnt : vcnt;
    col_sum = h + hs + 9'd8;
    row_sum = v + vs;
    return {layer, row_sum[7:3], col_sum[8:3], is_attr};
  endfunction

  // Register file write decode; a write lands after any fetch on the same edge.
  always_comb begin
    hscroll_d = hscroll_q;
    vscroll_d = vscroll_q;
    pri_d     = pri_q;
    case ({LATCH, CA[1:0]})
      3'b100: hscroll_d[CA[2]][7:0] = MDI;
      3'b101: begin
        hscroll_d[CA[2]][8] = MDI[0];
        pri_d[CA[2]]        = MDI[3:1];
      end
      3'b110: vscroll_d[CA[2]] = MDI;
      default: ;
    endcase
  end

  assign slot_s = HCNT[2:0];

  // Slot schedule: fetches in 0-3, CPU grants in 4/6, idle in 5/7.
  always_comb begin
    vram_a_d     = 13'd0;
    vram_we_d    = 1'b0;
    vram_do_d    = 8'd0;
    code_latch_d = 2'b00;
    attr_latch_d = 2'b00;
    grant_d      = 1'b0;
    pri_out_d    = pri_out_q;
    fine_out_d   = fine_out_q;
    cpu_ack_d    = grant_q;
    if (grant_q && !vram_we_q) begin
      cpu_rdata_d = VRAM_DI;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    case (slot_s)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        vram_a_d = fetch_addr(slot_s[1], slot_s[0], hscroll_q[slot_s[1]],
                              vscroll_q[slot_s[1]], HCNT, VCNT, FLIP);
        if (slot_s[0]) begin
          attr_latch_d[slot_s[1]] = 1'b1;
        end else begin
          code_latch_d[slot_s[1]] = 1'b1;
          pri_out_d[slot_s[1]]    = pri_q[slot_s[1]];
          fine_out_d[slot_s[1]]   = hscroll_q[slot_s[1]][2:0];
        end
      end
      3'd4, 3'd6: begin
        if (CPU_REQ) begin
          vram_a_d  = CPU_ADDR;
          vram_we_d = CPU_WE;
          vram_do_d = CPU_WDATA;
          grant_d   = 1'b1;
        end else begin
          grant_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any grant in flight.
  always_ff @(posedge CLK_6M) begin
    if (!RST_N) begin
      hscroll_q    <= '0;
      vscroll_q    <= '0;
      pri_q        <= '0;
      pri_out_q    <= '0;
      fine_out_q   <= '0;
      vram_a_q     <= 13'd0;
      vram_we_q    <= 1'b0;
      vram_do_q    <= 8'd0;
      code_latch_q <= 2'b00;
      attr_latch_q <= 2'b00;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'd0;
      grant_q      <= 1'b0;
    end else begin
      hscroll_q    <= hscroll_d;
      vscroll_q    <= vscroll_d;
      pri_q        <= pri_d;
      pri_out_q    <= pri_out_d;
      fine_out_q   <= fine_out_d;
      vram_a_q     <= vram_a_d;
      vram_we_q    <= vram_we_d;
      vram_do_q    <= vram_do_d;
      code_latch_q <= code_latch_d;
      attr_latch_q <= attr_latch_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      grant_q      <= grant_d;
    end
  end

  assign VRAM_A     = vram_a_q;
  assign VRAM_WE    = vram_we_q;
  assign VRAM_DO    = vram_do_q;
  assign CODE_LATCH = code_latch_q;
  assign ATTR_LATCH = attr_latch_q;
  assign CPU_ACK    = cpu_ack_q;
  assign CPU_RDATA  = cpu_rdata_q;
  assign PRI_A      = pri_out_q[0];
  assign PRI_B      = pri_out_q[1];
  assign FINE_A     = fine_out_q[0];
  assign FINE_B     = fine_out_q[1];

endmodule

// File: tb/tb_cus43_fetch_sequencer.sv
// Scoreboard bench for cus43_fetch_sequencer: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the slot schedule.
module tb_cus43_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [8:0]  hcnt;
  logic [7:0]  vcnt;
  logic        flip;
  logic        latch;
  logic [2:0]  ca;
  logic [7:0]  mdi;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  vram_di;
  logic [12:0] vram_a;
  logic        vram_we;
  logic [7:0]  vram_do;
  logic [1:0]  code_latch;
  logic [1:0]  attr_latch;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [2:0]  pri_a, pri_b, fine_a, fine_b;

  int compared   = 0;
  int mismatched = 0;

  cus43_fetch_sequencer dut (
    .CLK_6M(clk), .RST_N(rst_n), .HCNT(hcnt), .VCNT(vcnt), .FLIP(flip),
    .LATCH(latch), .CA(ca), .MDI(mdi), .CPU_REQ(cpu_req), .CPU_WE(cpu_we),
    .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata), .VRAM_DI(vram_di),
    .VRAM_A(vram_a), .VRAM_WE(vram_we), .VRAM_DO(vram_do),
    .CODE_LATCH(code_latch), .ATTR_LATCH(attr_latch), .CPU_ACK(cpu_ack),
    .CPU_RDATA(cpu_rdata), .PRI_A(pri_a), .PRI_B(pri_b), .FINE_A(fine_a), .FINE_B(fine_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fixed VRAM contents: every address returns a known pattern.
  function automatic logic [7:0] vram_pattern(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hA5;
  endfunction

  assign vram_di = vram_pattern(vram_a);

  typedef struct packed {
    logic [12:0] a;
    logic        a_chk;
    logic        we;
    logic [7:0]  dout;
    logic        grant;
    logic [1:0]  code;
    logic [1:0]  attr;
    logic        ack;
    logic [7:0]  rdata;
    logic [2:0]  pa, pb, fa, fb;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ack_q[$];

  // Reference model state
  int hs[2], vs[2], pr[2], pri_o[2], fine_o[2];
  int pend, pend_we, pend_data, rdata_o;

  task automatic model_step();
    exp_t e;
    int s, lay, h, v, col, row;
    e = '0;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        hs[i] = 0; vs[i] = 0; pr[i] = 0; pri_o[i] = 0; fine_o[i] = 0;
      end
      pend = 0; pend_we = 0; pend_data = 0; rdata_o = 0;
      e.a_chk = 1'b1;
      e.grant = 1'b1;
      exp_q.push_back(e);
      return;
    end
    e.ack = 1'(pend);
    if (pend != 0 && pend_we == 0) rdata_o = pend_data;
    if (pend != 0) ack_q.push_back(8'(rdata_o));
    pend = 0;
    s = int'(hcnt) % 8;
    if (s < 4) begin
      lay = s / 2;
      h = flip ? 511 - int'(hcnt) : int'(hcnt);
      v = flip ? 255 - int'(vcnt) : int'(vcnt);
      col = ((h + hs[lay] + 8) % 512) / 8;
      row = ((v + vs[lay]) % 256) / 8;
      e.a = 13'(lay * 4096 + row * 128 + col * 2 + (s % 2));
      e.a_chk = 1'b1;
      if (s % 2 == 0) begin
        e.code = 2'(1 << lay);
        pri_o[lay]  = pr[lay];
        fine_o[lay] = hs[lay] % 8;
      end else begin
        e.attr = 2'(1 << lay);
      end
    end else if ((s == 4 || s == 6) && cpu_req) begin
      e.a = cpu_addr; e.a_chk = 1'b1; e.we = cpu_we; e.dout = cpu_wdata; e.grant = 1'b1;
      pend = 1; pend_we = int'(cpu_we); pend_data = int'(vram_pattern(cpu_addr));
    end else if (s == 5 || s == 7) begin
      e.a_chk = 1'b1;
    end
    e.rdata = 8'(rdata_o);
    e.pa = 3'(pri_o[0]); e.pb = 3'(pri_o[1]);
    e.fa = 3'(fine_o[0]); e.fb = 3'(fine_o[1]);
    if (latch) begin
      lay = int'(ca[2]);
      case (ca[1:0])
        2'b00: hs[lay] = (hs[lay] & 256) | int'(mdi);
        2'b01: begin
          hs[lay] = (hs[lay] & 255) | (int'(mdi[0]) * 256);
          pr[lay] = (int'(mdi) >> 1) & 7;
        end
        2'b10: vs[lay] = int'(mdi);
        default: ;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per edge, plus an acknowledge transaction check.
  always @(posedge clk) begin
    exp_t e;
    logic ok;
    logic [7:0] ack_exp;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ok = (vram_we == e.we) && (code_latch == e.code) && (attr_latch == e.attr) &&
           (cpu_ack == e.ack) && (cpu_rdata == e.rdata) && (pri_a == e.pa) &&
           (pri_b == e.pb) && (fine_a == e.fa) && (fine_b == e.fb) &&
           (!e.a_chk || vram_a == e.a) && (!e.grant || vram_do == e.dout);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL cycle t=%0t: got a=%h we=%b do=%h code=%b attr=%b ack=%b rd=%h pa=%0d pb=%0d fa=%0d fb=%0d | exp a=%h(chk%b) we=%b do=%h(chk%b) code=%b attr=%b ack=%b rd=%h pa=%0d pb=%0d fa=%0d fb=%0d",
                 $time, vram_a, vram_we, vram_do, code_latch, attr_latch, cpu_ack, cpu_rdata,
                 pri_a, pri_b, fine_a, fine_b, e.a, e.a_chk, e.we, e.dout, e.grant, e.code,
                 e.attr, e.ack, e.rdata, e.pa, e.pb, e.fa, e.fb);
      end
    end
    if (cpu_ack) begin
      compared++;
      if (ack_q.size() == 0) begin
        mismatched++;
        $display("FAIL ack_unexpected: got CPU_ACK=1 with no access outstanding");
      end else begin
        ack_exp = ack_q.pop_front();
        if (cpu_rdata != ack_exp) begin
          mismatched++;
          $display("FAIL ack_rdata: got %h exp %h", cpu_rdata, ack_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    compared++;
    if (got != expv) begin
      mismatched++;
      $display("FAIL %s: got %0h exp %0h", name, got, expv);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    hcnt = 9'd5; latch = 1'b1; ca = sel; mdi = data;
    step();
    latch = 1'b0;
  endtask

  int wait_cnt;
  int rst_left;

  initial begin
    rst_n = 1'b0; hcnt = 9'd0; vcnt = 8'd0; flip = 1'b0;
    latch = 1'b1; ca = 3'b000; mdi = 8'hFF;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_ack", int'(cpu_ack), 0);
      chk("reset_addr", int'(vram_a), 0);
    end
    rst_n = 1'b1; latch = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("post_reset_addr", int'(vram_a), 'h002);
    chk("post_reset_code", int'(code_latch), 1);

    wr(3'b000, 8'h10); wr(3'b001, 8'h00); wr(3'b010, 8'h03);
    wr(3'b100, 8'h10); wr(3'b101, 8'h00); wr(3'b110, 8'h03);
    vcnt = 8'h25;
    hcnt = 9'd0; step();
    chk("fetch_a_code", int'(vram_a), 'h286);
    chk("fetch_a_code_strobe", int'(code_latch), 1);
    hcnt = 9'd1; step();
    chk("fetch_a_attr", int'(vram_a), 'h287);
    chk("fetch_a_attr_strobe", int'(attr_latch), 1);
    hcnt = 9'd2; step();
    chk("fetch_b_code", int'(vram_a), 'h1286);
    chk("fetch_b_code_strobe", int'(code_latch), 2);

    wr(3'b000, 8'h00);
    vcnt = 8'd0;
    hcnt = 9'h1F8; step();
    chk("wrap_hcnt", int'(vram_a), 'h000);
    wr(3'b000, 8'hFF); wr(3'b001, 8'h01);
    hcnt = 9'd0; step();
    chk("wrap_hscroll_col", int'(vram_a[6:1]), 0);
    wr(3'b000, 8'h00); wr(3'b001, 8'h00);
    flip = 1'b1;
    hcnt = 9'd0; step();
    chk("wrap_flip_col", int'(vram_a[6:1]), 0);
    flip = 1'b0;

    hcnt = 9'd1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0ABC; cpu_wdata = 8'h00;
    step();
    for (int s = 2; s <= 5; s++) begin
      hcnt = 9'(s); step();
      if (s < 4) chk("read_no_early_grant", int'(vram_we), 0);
      if (s == 4) chk("read_grant_addr", int'(vram_a), 'h0ABC);
      if (s == 5) begin
        chk("read_ack", int'(cpu_ack), 1);
        chk("read_rdata", int'(cpu_rdata), int'(vram_pattern(13'h0ABC)));
      end
    end
    cpu_req = 1'b0;

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 8'h77;
    for (int s = 0; s < 8; s++) begin
      hcnt = 9'(9'h040 + 9'(s)); step();
      chk("b2b_we", int'(vram_we), (s == 4 || s == 6) ? 1 : 0);
      chk("b2b_ack", int'(cpu_ack), (s == 5 || s == 7) ? 1 : 0);
    end
    cpu_req = 1'b0;

    hcnt = 9'h04A; latch = 1'b1; ca = 3'b001; mdi = 8'h0A; step();
    hcnt = 9'h04B; ca = 3'b000; mdi = 8'h13; step();
    latch = 1'b0;
    for (int s = 4; s < 8; s++) begin
      hcnt = 9'(9'h048 + 9'(s)); step();
    end
    chk("pri_shadow_old", int'(pri_a), 0);
    chk("fine_shadow_old", int'(fine_a), 0);
    hcnt = 9'h050; step();
    chk("pri_shadow_new", int'(pri_a), 5);
    chk("fine_shadow_new", int'(fine_a), 3);

    wait_cnt = 0; rst_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hcnt[2:0] == 3'd7 && $urandom_range(0, 15) == 0) begin
        hcnt = 9'($urandom_range(0, 63) * 8);
        vcnt = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) flip = ~flip;
      end else begin
        hcnt = hcnt + 9'd1;
      end
      latch = ($urandom_range(0, 3) == 0);
      ca    = 3'($urandom_range(0, 7));
      mdi   = 8'($urandom_range(0, 255));
      if (rst_left > 0) begin
        rst_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_left = $urandom_range(1, 3);
      end
      rst_n = (rst_left == 0);
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (cpu_req && cpu_ack) begin
        wait_cnt = 0;
        if ($urandom_range(0, 3) != 0) cpu_req = 1'b0;
      end else if (cpu_req) begin
        wait_cnt++;
        if (wait_cnt > 8) begin
          chk("cpu_ack_timeout", wait_cnt, 0);
          cpu_req = 1'b0;
          wait_cnt = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 8191));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      step();
    end

    cpu_req = 1'b0; latch = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hcnt = hcnt + 9'd1; step();
    end
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
